// File: rtl/rv_mc_control_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: opcodes, ULA op codes,
// mux select encodings and state encodings.
package rv_mc_control_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned SEL_W   = 2;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [SEL_W-1:0] ULA_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ULA_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ULA_RTYPE = 2'b10;
  localparam logic [SEL_W-1:0] ULA_ITYPE = 2'b11;

  localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_REG    = 2'b10;
  localparam logic [SEL_W-1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [SEL_W-1:0] SRC_B_REG  = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'b10;

  localparam logic [SEL_W-1:0] PC_SRC_ULA    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;

  localparam logic [SEL_W-1:0] WB_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] WB_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] WB_PC     = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_LUI      = 4'd9,
    S_ALU_WB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_JALR     = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

endpackage

// File: rtl/rv_mc_control.sv
// Multicycle RV32I main control FSM with retired-instruction counter.
// RV_MC_ILLEGAL_TRAP_EN: illegal decodes park in a sticky TRAP state instead of acting as NOPs.
module rv_mc_control
  import rv_mc_control_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_source,
  output logic [1:0]           ula_src_a,
  output logic [1:0]           ula_src_b,
  output logic [1:0]           ula_op,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 illegal_inst,
  output logic [INSTRET_W-1:0] instret
);

  state_t                 state, state_nxt;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   retire;
  logic                   illegal_nxt;

  // State register; reset drops any in-flight access since outputs decode from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

`ifdef RV_MC_ILLEGAL_TRAP_EN
  assign illegal_nxt = 1'b1;
`else
  assign illegal_nxt = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_or_d       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_source    = PC_SRC_ULA;
    ula_src_a    = SRC_A_PC;
    ula_src_b    = SRC_B_REG;
    ula_op       = ULA_ADD;
    reg_write    = 1'b0;
    wb_sel       = WB_ALUOUT;
    illegal_inst = 1'b0;
    unique case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        ula_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ula_src_a = SRC_A_OLD_PC;
        ula_src_b = SRC_B_IMM;
        state_nxt = illegal_nxt ? S_TRAP : S_FETCH;
        unique case (opcode)
          OPC_LOAD, OPC_STORE: state_nxt = S_MEM_ADDR;
          OPC_RTYPE:           state_nxt = S_EXEC_R;
          OPC_ITYPE:           state_nxt = S_EXEC_I;
          OPC_BRANCH:          if (funct3 == 3'b000 || funct3 == 3'b001) state_nxt = S_BRANCH;
          OPC_JAL:             state_nxt = S_JAL;
          OPC_JALR:            state_nxt = S_JALR;
          OPC_LUI:             state_nxt = S_LUI;
          OPC_AUIPC:           state_nxt = S_ALU_WB;
          default:             ;
        endcase
      end
      S_MEM_ADDR: begin
        ula_src_a = SRC_A_REG;
        ula_src_b = SRC_B_IMM;
        state_nxt = (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_MDR;
        state_nxt = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_EXEC_R: begin
        ula_src_a = SRC_A_REG;
        ula_op    = ULA_RTYPE;
        state_nxt = S_ALU_WB;
      end
      S_EXEC_I: begin
        ula_src_a = SRC_A_REG;
        ula_src_b = SRC_B_IMM;
        ula_op    = ULA_ITYPE;
        state_nxt = S_ALU_WB;
      end
      S_LUI: begin
        ula_src_a = SRC_A_ZERO;
        ula_src_b = SRC_B_IMM;
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ula_src_a = SRC_A_REG;
        ula_op    = ULA_SUB;
        pc_source = PC_SRC_ALUOUT;
        pc_write  = funct3[0] ? !zero : zero;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_ALUOUT;
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        state_nxt = S_FETCH;
      end
      S_JALR: begin
        ula_src_a = SRC_A_REG;
        ula_src_b = SRC_B_IMM;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        state_nxt = S_FETCH;
      end
      S_TRAP: begin
        // Only reachable with trapping enabled; left by reset alone.
        illegal_inst = illegal_nxt;
        state_nxt    = illegal_nxt ? S_TRAP : S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A retire is any return to FETCH from an execute/writeback state; DECODE->FETCH is an illegal NOP.
  assign retire = (state_nxt == S_FETCH) && (state != S_IDLE) &&
                  (state != S_FETCH) && (state != S_DECODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + INSTRET_W'(1);
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_rv_mc_control.sv
// Directed self-checking bench for rv_mc_control (narrow instret so wrap is reachable).
module tb_rv_mc_control;

  localparam int unsigned IW = 4;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  logic          clk;
  logic          rst_n;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          zero;
  logic          mem_ready;
  logic          mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, illegal_inst;
  logic [1:0]    pc_source, ula_src_a, ula_src_b, ula_op, wb_sel;
  logic [IW-1:0] instret;
  logic [16:0]   act;

  rv_mc_control #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source), .ula_src_a(ula_src_a),
    .ula_src_b(ula_src_b), .ula_op(ula_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .illegal_inst(illegal_inst), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
                ula_src_a, ula_src_b, ula_op, reg_write, wb_sel, illegal_inst};

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic       rdy;
    logic [16:0] exp;
    logic [IW-1:0] ins;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [16:0] o(input logic mr, mw, iod, irw, pcw, input logic [1:0] pcs,
                                    input logic [1:0] sa, sb, uo, input logic rw,
                                    input logic [1:0] wb, input logic ill);
    return {mr, mw, iod, irw, pcw, pcs, sa, sb, uo, rw, wb, ill};
  endfunction

  logic [16:0] Z, F1, F0, DEC, MADDR, MRD, MWB, MWR, EXR, EXI, LUIO, AWB;
  logic [16:0] BRT, BRN, JALO, JALRO, TRAPO;

  task automatic add(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, input logic rdy, input logic [16:0] e, input logic [IW-1:0] ins);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.z = z; v.rdy = rdy; v.exp = e; v.ins = ins;
    vecs.push_back(v);
  endtask

  task automatic chk_o(input string nm, input logic [16:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b", nm, act, e);
    end
  endtask

  task automatic chk_i(input string nm, input logic [IW-1:0] e);
    checks++;
    if (instret !== e) begin
      errors++;
      $display("FAIL %s: instret got %0d expected %0d", nm, instret, e);
    end
  endtask

  task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic rdy);
    @(negedge clk);
    opcode = op; funct3 = f3; zero = z; mem_ready = rdy;
  endtask

  // One R-type instruction starting in FETCH: FETCH, DECODE, EXEC_R, ALU_WB.
  task automatic run_r();
    repeat (4) cyc(OP_R, 3'b000, 1'b0, 1'b1);
  endtask

  initial begin
    Z     = '0;
    F1    = o(1,0,0,1,1,2'b00,2'b00,2'b01,2'b00,0,2'b00,0);
    F0    = o(1,0,0,0,0,2'b00,2'b00,2'b01,2'b00,0,2'b00,0);
    DEC   = o(0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0,2'b00,0);
    MADDR = o(0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,0,2'b00,0);
    MRD   = o(1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,2'b00,0);
    MWB   = o(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,2'b01,0);
    MWR   = o(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0,2'b00,0);
    EXR   = o(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,2'b00,0);
    EXI   = o(0,0,0,0,0,2'b00,2'b10,2'b10,2'b11,0,2'b00,0);
    LUIO  = o(0,0,0,0,0,2'b00,2'b11,2'b10,2'b00,0,2'b00,0);
    AWB   = o(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,2'b00,0);
    BRT   = o(0,0,0,0,1,2'b01,2'b10,2'b00,2'b01,0,2'b00,0);
    BRN   = o(0,0,0,0,0,2'b01,2'b10,2'b00,2'b01,0,2'b00,0);
    JALO  = o(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,1,2'b10,0);
    JALRO = o(0,0,0,0,1,2'b00,2'b10,2'b10,2'b00,1,2'b10,0);
    TRAPO = o(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,2'b00,1);

    add("r_fetch",   OP_R,  3'b000, 0, 1, F1,    4'd0);
    add("r_decode",  OP_R,  3'b000, 0, 1, DEC,   4'd0);
    add("r_exec",    OP_R,  3'b000, 0, 1, EXR,   4'd0);
    add("r_wb",      OP_R,  3'b000, 0, 1, AWB,   4'd0);
    add("ld_fwait",  OP_LD, 3'b010, 0, 0, F0,    4'd1);
    add("ld_fetch",  OP_LD, 3'b010, 0, 1, F1,    4'd1);
    add("ld_decode", OP_LD, 3'b010, 0, 1, DEC,   4'd1);
    add("ld_addr",   OP_LD, 3'b010, 0, 1, MADDR, 4'd1);
    add("ld_wait1",  OP_LD, 3'b010, 0, 0, MRD,   4'd1);
    add("ld_wait2",  OP_LD, 3'b010, 0, 0, MRD,   4'd1);
    add("ld_wait3",  OP_LD, 3'b010, 0, 0, MRD,   4'd1);
    add("ld_done",   OP_LD, 3'b010, 0, 1, MRD,   4'd1);
    add("ld_wb",     OP_LD, 3'b010, 0, 1, MWB,   4'd1);
    add("beq_fetch", OP_BR, 3'b000, 1, 1, F1,    4'd2);
    add("beq_dec",   OP_BR, 3'b000, 1, 1, DEC,   4'd2);
    add("beq_taken", OP_BR, 3'b000, 1, 1, BRT,   4'd2);
    add("beq2_fet",  OP_BR, 3'b000, 0, 1, F1,    4'd3);
    add("beq2_dec",  OP_BR, 3'b000, 0, 1, DEC,   4'd3);
    add("beq_not",   OP_BR, 3'b000, 0, 1, BRN,   4'd3);
    add("bne_fetch", OP_BR, 3'b001, 0, 1, F1,    4'd4);
    add("bne_dec",   OP_BR, 3'b001, 0, 1, DEC,   4'd4);
    add("bne_taken", OP_BR, 3'b001, 0, 1, BRT,   4'd4);
    add("jal_fetch", OP_JAL,3'b000, 0, 1, F1,    4'd5);
    add("jal_dec",   OP_JAL,3'b000, 0, 1, DEC,   4'd5);
    add("jal",       OP_JAL,3'b000, 0, 1, JALO,  4'd5);
    add("jr_fetch",  OP_JR, 3'b000, 0, 1, F1,    4'd6);
    add("jr_dec",    OP_JR, 3'b000, 0, 1, DEC,   4'd6);
    add("jalr",      OP_JR, 3'b000, 0, 1, JALRO, 4'd6);
    add("i_fetch",   OP_I,  3'b000, 0, 1, F1,    4'd7);
    add("i_dec",     OP_I,  3'b000, 0, 1, DEC,   4'd7);
    add("i_exec",    OP_I,  3'b000, 0, 1, EXI,   4'd7);
    add("i_wb",      OP_I,  3'b000, 0, 1, AWB,   4'd7);
    add("lui_fetch", OP_LUI,3'b000, 0, 1, F1,    4'd8);
    add("lui_dec",   OP_LUI,3'b000, 0, 1, DEC,   4'd8);
    add("lui",       OP_LUI,3'b000, 0, 1, LUIO,  4'd8);
    add("lui_wb",    OP_LUI,3'b000, 0, 1, AWB,   4'd8);
    add("aui_fetch", OP_AUI,3'b000, 0, 1, F1,    4'd9);
    add("aui_dec",   OP_AUI,3'b000, 0, 1, DEC,   4'd9);
    add("aui_wb",    OP_AUI,3'b000, 0, 1, AWB,   4'd9);
    add("st_fetch",  OP_ST, 3'b010, 0, 1, F1,    4'd10);
    add("st_dec",    OP_ST, 3'b010, 0, 1, DEC,   4'd10);
    add("st_addr",   OP_ST, 3'b010, 0, 1, MADDR, 4'd10);
    add("st_wait",   OP_ST, 3'b010, 0, 0, MWR,   4'd10);
    add("st_done",   OP_ST, 3'b010, 0, 1, MWR,   4'd10);
    add("bad_fetch", OP_BAD,3'b000, 0, 1, F1,    4'd11);
    add("bad_dec",   OP_BAD,3'b000, 0, 1, DEC,   4'd11);
`ifdef RV_MC_ILLEGAL_TRAP_EN
    add("trap1",     OP_R,  3'b000, 0, 1, TRAPO, 4'd11);
    add("trap2",     OP_R,  3'b000, 0, 1, TRAPO, 4'd11);
    add("trap3",     OP_R,  3'b000, 1, 0, TRAPO, 4'd11);
`else
    add("nop_fetch", OP_BR, 3'b010, 0, 1, F1,    4'd11);
    add("bf3_dec",   OP_BR, 3'b010, 0, 1, DEC,   4'd11);
    add("nop2_fet",  OP_R,  3'b000, 0, 0, F0,    4'd11);
`endif

    rst_n = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    #1 chk_o("reset_out", Z);
    chk_i("reset_instret", '0);
    #1 rst_n = 1'b1;
    #1 chk_o("idle_out", Z);

    foreach (vecs[k]) begin
      cyc(vecs[k].op, vecs[k].f3, vecs[k].z, vecs[k].rdy);
      #1 chk_o(vecs[k].name, vecs[k].exp);
      chk_i(vecs[k].name, vecs[k].ins);
    end

    // Reset in the middle of a store access.
    cyc(OP_R, 3'b000, 0, 0);
    rst_n = 1'b0;
    #1 chk_o("rst2_out", Z);
    #1 rst_n = 1'b1;
    #1 chk_o("rst2_idle", Z);
    run_r();
    cyc(OP_ST, 3'b010, 0, 0);
    #1 chk_i("pre_st_instret", 4'd1);
    cyc(OP_ST, 3'b010, 0, 1);
    cyc(OP_ST, 3'b010, 0, 1);
    cyc(OP_ST, 3'b010, 0, 1);
    cyc(OP_ST, 3'b010, 0, 0);
    #1 chk_o("st_pending", MWR);
    rst_n = 1'b0;
    #1 chk_o("st_reset_out", Z);
    chk_i("st_reset_instret", '0);
    #1 rst_n = 1'b1;
    #1 chk_o("st_reset_idle", Z);
    cyc(OP_R, 3'b000, 0, 0);
    #1 chk_o("restart_fetch", F0);
    chk_i("restart_instret", '0);

    // Counter wrap at all-ones.
    repeat (15) run_r();
    cyc(OP_R, 3'b000, 0, 0);
    #1 chk_i("instret_max", 4'hf);
    run_r();
    cyc(OP_R, 3'b000, 0, 0);
    #1 chk_i("instret_wrap", 4'h0);
    chk_o("wrap_fetch", F0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
